// File: rtl/debug_tx_serializer.sv
// Serialises a DATA_WIDTH debug word into DATA_WIDTH_UART-sized bytes, MSB first,
// handing one byte at a time to a UART transmitter with a per-byte ack timeout.
module debug_tx_serializer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_send,
  input  logic [DATA_WIDTH-1:0]      i_word,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_result,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [1:0]                 o_state
);

  // DATA_WIDTH must be an integer multiple of DATA_WIDTH_UART.
  localparam int NBYTES = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TCW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [TCW-1:0] TIME_LIM  = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                       state, next_state;
  logic [DATA_WIDTH-1:0]        shift_q;
  logic [DATA_WIDTH-1:0]        shift_next;
  logic [DATA_WIDTH_UART-1:0]   tx_result_q;
  logic [BCW-1:0]               byte_cnt;
  logic [TCW-1:0]               wait_cnt;
  logic                         error_q;
  logic                         accept;
  logic                         advance;
  logic                         timeout;

  // Handshake: i_send is a one-cycle request honoured only in IDLE (no back-pressure,
  // requests while busy are dropped); o_tx_signal is a one-cycle start strobe and
  // i_tx_done is the transmitter's one-cycle completion, honoured only in WAIT.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    advance    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: if (i_send) begin
        accept     = 1'b1;
        next_state = SEND;
      end
      SEND: next_state = WAIT;
      WAIT: begin
        // A completion on the limit cycle still counts: done wins over timeout.
        if (i_tx_done) begin
          if (byte_cnt == LAST_BYTE) begin
            next_state = DONE;
          end else begin
            advance    = 1'b1;
            next_state = SEND;
          end
        end else if (wait_cnt == TIME_LIM) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign shift_next = shift_q << DATA_WIDTH_UART;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_q     <= '0;
      tx_result_q <= '0;
      byte_cnt    <= '0;
      wait_cnt    <= '0;
      error_q     <= 1'b0;
    end else begin
      if (accept) begin
        shift_q     <= i_word;
        tx_result_q <= i_word[DATA_WIDTH-1 -: DATA_WIDTH_UART];
        byte_cnt    <= '0;
        error_q     <= 1'b0;
      end
      if (advance) begin
        shift_q     <= shift_next;
        tx_result_q <= shift_next[DATA_WIDTH-1 -: DATA_WIDTH_UART];
        byte_cnt    <= byte_cnt + BCW'(1);
      end
      if (state == SEND) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !i_tx_done && !timeout) begin
        wait_cnt <= wait_cnt + TCW'(1);
      end
      if (timeout) error_q <= 1'b1;
    end
  end

  assign o_tx_signal = (state == SEND);
  assign o_tx_result = tx_result_q;
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_error     = error_q;
  assign o_state     = state;

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Directed bench for debug_tx_serializer: byte order, ignored requests, timeout,
// done-vs-timeout priority, spurious acks and asynchronous reset abort.
module tb_debug_tx_serializer;

  logic        clk;
  logic        i_reset;
  logic        i_send;
  logic [31:0] i_word;
  logic        i_tx_done;
  logic        o_tx_signal;
  logic [7:0]  o_tx_result;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [1:0]  o_state;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int unstable_cnt = 0;
  logic [7:0] last_sent = '0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  debug_tx_serializer #(
    .DATA_WIDTH(32),
    .DATA_WIDTH_UART(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_send(i_send),
    .i_word(i_word),
    .i_tx_done(i_tx_done),
    .o_tx_signal(o_tx_signal),
    .o_tx_result(o_tx_result),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error),
    .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: record every byte strobed out, count done pulses, watch WAIT stability
  always @(negedge clk) begin
    if (o_tx_signal) begin
      got_q.push_back(o_tx_result);
      last_sent = o_tx_result;
    end
    if (o_done) done_cnt++;
    if (o_state == 2'd2 && o_tx_result !== last_sent) unstable_cnt++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_send(input logic [31:0] w, input logic spur_done);
    i_send    = 1'b1;
    i_word    = w;
    i_tx_done = spur_done;
    step();
    i_send    = 1'b0;
    i_word    = '0;
    i_tx_done = 1'b0;
  endtask

  // Acks n bytes; each ack arrives 'delay' cycles after its o_tx_signal.
  task automatic ack_bytes(input int n, input int delay, input bit inject);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 50 && !o_tx_signal; k++) step();
      if (!o_tx_signal) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL wait_tx_signal: got no strobe within 50 cycles, want strobe for byte %0d", b);
      end
      if (inject) begin
        i_send = 1'b1;
        i_word = '1;
      end
      step();
      i_send = 1'b0;
      repeat (delay - 1) step();
      i_tx_done = 1'b1;
      if (inject) begin
        i_send = 1'b1;
        i_word = '1;
      end
      step();
      i_tx_done = 1'b0;
      i_send    = 1'b0;
      i_word    = '0;
    end
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    done_cnt     = 0;
    unstable_cnt = 0;
  endtask

  // tests
  task automatic test_reset();
    i_reset = 1'b0; i_send = 1'b0; i_word = '0; i_tx_done = 1'b0;
    repeat (3) step();
    cmp_cnt++;
    if ({o_tx_signal, o_busy, o_done, o_error} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_flags: got sig/busy/done/err=%b want 0000", {o_tx_signal, o_busy, o_done, o_error});
    end
    cmp_cnt++;
    if (o_tx_result !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_result: got %h want 00", o_tx_result);
    end
    cmp_cnt++;
    if (o_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got %0d want 0", o_state);
    end
    #2 i_reset = 1'b1;
  endtask

  task automatic test_basic();
    clear_sb();
    exp_q = '{8'h80, 8'hE1, 8'h70, 8'h21};
    start_send(32'h80E17021, 1'b0);
    cmp_cnt++;
    if (o_tx_signal !== 1'b1 || o_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_first_accept: got sig=%b busy=%b want 1 1", o_tx_signal, o_busy);
    end
    ack_bytes(4, 3, 1'b0);
    cmp_cnt++;
    if (o_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_done_pulse: got %b want 1", o_done);
    end
    step();
    cmp_cnt++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_idle_after: got done=%b busy=%b want 0 0", o_done, o_busy);
    end
    step();
    cmp_cnt++;
    if (got_q.size() !== exp_q.size()) begin
      err_cnt++;
      $display("FAIL basic_byte_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL basic_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 1 || unstable_cnt !== 0) begin
      err_cnt++;
      $display("FAIL basic_done_stable: got done_cnt=%0d unstable=%0d want 1 0", done_cnt, unstable_cnt);
    end
  endtask

  task automatic test_ignore_send();
    clear_sb();
    exp_q = '{8'h80, 8'hE1, 8'h70, 8'h21};
    start_send(32'h80E17021, 1'b0);
    ack_bytes(4, 3, 1'b1);
    repeat (4) step();
    cmp_cnt++;
    if (got_q.size() !== exp_q.size()) begin
      err_cnt++;
      $display("FAIL ignore_byte_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL ignore_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    cmp_cnt++;
    if (done_cnt !== 1 || o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL ignore_done: got done_cnt=%0d busy=%b want 1 0", done_cnt, o_busy);
    end
  endtask

  task automatic test_timeout();
    clear_sb();
    exp_q = '{8'h11, 8'h22, 8'h33};
    start_send(32'h11223344, 1'b0);
    ack_bytes(2, 2, 1'b0);
    repeat (16) step();
    cmp_cnt++;
    if (o_state !== 2'd2 || o_error !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_early: got state=%0d err=%b want 2 0", o_state, o_error);
    end
    step();
    cmp_cnt++;
    if (o_error !== 1'b1 || o_busy !== 1'b0 || o_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL timeout_flag: got err=%b busy=%b state=%0d want 1 0 0", o_error, o_busy, o_state);
    end
    repeat (5) step();
    cmp_cnt++;
    if (o_error !== 1'b1) begin
      err_cnt++;
      $display("FAIL timeout_sticky: got %b want 1", o_error);
    end
    cmp_cnt++;
    if (done_cnt !== 0 || got_q.size() !== 3) begin
      err_cnt++;
      $display("FAIL timeout_no_done: got done_cnt=%0d bytes=%0d want 0 3", done_cnt, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL timeout_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    clear_sb();
    start_send(32'hA5A55A5A, 1'b0);
    cmp_cnt++;
    if (o_error !== 1'b0 || o_tx_result !== 8'hA5) begin
      err_cnt++;
      $display("FAIL error_clear: got err=%b byte=%h want 0 a5", o_error, o_tx_result);
    end
    ack_bytes(4, 1, 1'b0);
    repeat (2) step();
    cmp_cnt++;
    if (done_cnt !== 1 || got_q.size() !== 4) begin
      err_cnt++;
      $display("FAIL error_clear_xfer: got done_cnt=%0d bytes=%0d want 1 4", done_cnt, got_q.size());
    end
  endtask

  task automatic test_done_at_limit();
    clear_sb();
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    start_send(32'hDEADBEEF, 1'b0);
    ack_bytes(4, 16, 1'b0);
    cmp_cnt++;
    if (o_done !== 1'b1 || o_error !== 1'b0) begin
      err_cnt++;
      $display("FAIL limit_done: got done=%b err=%b want 1 0", o_done, o_error);
    end
    repeat (2) step();
    cmp_cnt++;
    if (got_q.size() !== exp_q.size() || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL limit_count: got bytes=%0d done_cnt=%0d want 4 1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL limit_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_spurious_done();
    clear_sb();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    cmp_cnt++;
    if (o_busy !== 1'b0 || o_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL spur_idle: got busy=%b state=%0d want 0 0", o_busy, o_state);
    end
    start_send(32'h01020304, 1'b1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    cmp_cnt++;
    if (o_state !== 2'd2 || o_tx_result !== 8'h01) begin
      err_cnt++;
      $display("FAIL spur_send: got state=%0d byte=%h want 2 01", o_state, o_tx_result);
    end
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    ack_bytes(3, 2, 1'b0);
    repeat (2) step();
    cmp_cnt++;
    if (got_q.size() !== exp_q.size() || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL spur_count: got bytes=%0d done_cnt=%0d want 4 1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL spur_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    clear_sb();
    start_send(32'hCAFEF00D, 1'b0);
    ack_bytes(1, 2, 1'b0);
    step();
    #2 i_reset = 1'b0;
    #1;
    cmp_cnt++;
    if ({o_tx_signal, o_busy, o_done, o_error} !== 4'b0000 || o_tx_result !== 8'h00 || o_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL abort_async: got sig/busy/done/err=%b byte=%h state=%0d want 0000 00 0",
               {o_tx_signal, o_busy, o_done, o_error}, o_tx_result, o_state);
    end
    repeat (2) step();
    #2 i_reset = 1'b1;
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    repeat (20) step();
    cmp_cnt++;
    if (got_q.size() !== 2 || done_cnt !== 0 || o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_quiet: got bytes=%0d done_cnt=%0d busy=%b want 2 0 0", got_q.size(), done_cnt, o_busy);
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_ignore_send();
    test_timeout();
    test_done_at_limit();
    test_spurious_done();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
